// File: rtl/multichannel_lockin.sv
// N-channel lock-in demodulator: one shared multiplier walks every channel against sin/cos,
// integrates over 2^DECIM_LOG2 samples and dumps saturated, scaled X/Y per channel.
//   state   | meaning
//   IDLE    | waiting for tick_i
//   MAC     | 2*NUM_CH multiply steps, products accumulated one cycle later
//   DRAIN   | last product accumulated, decide dump or next sample
//   DUMP    | scale/saturate accumulators to x_o/y_o, clear block state
module multichannel_lockin #(
    parameter int NUM_CH     = 4,
    parameter int NUM_BITS   = 24,
    parameter int DECIM_LOG2 = 7
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tick_i,
    input  logic [NUM_CH*NUM_BITS-1:0] sig_i,
    input  logic [NUM_BITS-1:0]        sin_i,
    input  logic [NUM_BITS-1:0]        cos_i,
    output logic [NUM_CH*NUM_BITS-1:0] x_o,
    output logic [NUM_CH*NUM_BITS-1:0] y_o,
    output logic                       done_o,
    output logic                       busy_o,
    output logic                       drop_o,
    output logic [31:0]                count_o
);

    localparam int ACC_BITS  = 2*NUM_BITS + DECIM_LOG2 + 1;
    localparam int OUT_SHIFT = NUM_BITS - 1 + DECIM_LOG2;
    localparam int PROD_BITS = 2*NUM_BITS;
    localparam int STEPS     = 2*NUM_CH;
    localparam int STEP_W    = $clog2(STEPS);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W     = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [CNT_W-1:0]  SAMP_LAST = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic signed [ACC_BITS-1:0] SAT_MAX =
        {{(ACC_BITS-NUM_BITS+1){1'b0}}, {(NUM_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] SAT_MIN =
        {{(ACC_BITS-NUM_BITS+1){1'b1}}, {(NUM_BITS-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_DUMP} state_t;

    state_t state_q, state_d;
    logic   load, drop_set;

    logic signed [NUM_BITS-1:0]  sig_q [NUM_CH];
    logic signed [NUM_BITS-1:0]  sin_q, cos_q;
    logic [STEP_W-1:0]           step_q;
    logic [CNT_W-1:0]            samp_cnt_q;
    logic signed [PROD_BITS-1:0] prod_q;
    logic [CH_W-1:0]             prod_ch_q;
    logic                        prod_is_y_q;
    logic                        prod_vld_q;
    logic signed [ACC_BITS-1:0]  acc_x [NUM_CH];
    logic signed [ACC_BITS-1:0]  acc_y [NUM_CH];

    logic [CH_W-1:0]             mul_ch;
    logic signed [NUM_BITS-1:0]  mul_a, mul_b;
    logic signed [PROD_BITS-1:0] mul_p;
    logic signed [ACC_BITS-1:0]  prod_ext;

    function automatic logic [NUM_BITS-1:0] sat(input logic signed [ACC_BITS-1:0] a);
        logic signed [ACC_BITS-1:0] s;
        s = a >>> OUT_SHIFT;
        if (s > SAT_MAX)
            return SAT_MAX[NUM_BITS-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[NUM_BITS-1:0];
        else
            return s[NUM_BITS-1:0];
    endfunction

    assign mul_ch   = CH_W'(step_q >> 1);
    assign mul_a    = sig_q[mul_ch];
    assign mul_b    = step_q[0] ? cos_q : sin_q;
    assign mul_p    = mul_a * mul_b;
    assign prod_ext = {{(ACC_BITS-PROD_BITS){prod_q[PROD_BITS-1]}}, prod_q};
    assign busy_o   = (state_q != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // A tick landing on the cycle the FSM would return to IDLE starts the next sample directly.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        drop_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick_i) begin
                    load    = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                drop_set = tick_i;
                if (step_q == STEP_LAST)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (samp_cnt_q == SAMP_LAST) begin
                    drop_set = tick_i;
                    state_d  = S_DUMP;
                end else if (tick_i) begin
                    load    = 1'b1;
                    state_d = S_MAC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DUMP: begin
                if (tick_i) begin
                    load    = 1'b1;
                    state_d = S_MAC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sig_q[k] <= '0;
                acc_x[k] <= '0;
                acc_y[k] <= '0;
            end
            sin_q       <= '0;
            cos_q       <= '0;
            step_q      <= '0;
            samp_cnt_q  <= '0;
            prod_q      <= '0;
            prod_ch_q   <= '0;
            prod_is_y_q <= 1'b0;
            prod_vld_q  <= 1'b0;
            x_o         <= '0;
            y_o         <= '0;
            done_o      <= 1'b0;
            drop_o      <= 1'b0;
            count_o     <= '0;
        end else begin
            done_o     <= 1'b0;
            prod_vld_q <= (state_q == S_MAC);

            if (load) begin
                for (int k = 0; k < NUM_CH; k++)
                    sig_q[k] <= sig_i[k*NUM_BITS +: NUM_BITS];
                sin_q  <= sin_i;
                cos_q  <= cos_i;
                step_q <= '0;
            end else if (state_q == S_MAC) begin
                step_q <= step_q + 1'b1;
            end

            if (state_q == S_MAC) begin
                prod_q      <= mul_p;
                prod_ch_q   <= mul_ch;
                prod_is_y_q <= step_q[0];
            end

            if (prod_vld_q) begin
                if (prod_is_y_q)
                    acc_y[prod_ch_q] <= acc_y[prod_ch_q] + prod_ext;
                else
                    acc_x[prod_ch_q] <= acc_x[prod_ch_q] + prod_ext;
            end

            if (state_q == S_DRAIN && samp_cnt_q != SAMP_LAST)
                samp_cnt_q <= samp_cnt_q + 1'b1;

            if (state_q == S_DUMP) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    x_o[k*NUM_BITS +: NUM_BITS] <= sat(acc_x[k]);
                    y_o[k*NUM_BITS +: NUM_BITS] <= sat(acc_y[k]);
                    acc_x[k] <= '0;
                    acc_y[k] <= '0;
                end
                samp_cnt_q <= '0;
                count_o    <= count_o + 32'd1;
                done_o     <= 1'b1;
            end

            if (drop_set)
                drop_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multichannel_lockin.sv
// Directed bench for multichannel_lockin with 2 channels, 24-bit data, 4-sample decimation.
module tb_multichannel_lockin;

    localparam int NC = 2;
    localparam int NB = 24;
    localparam int DL = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               tick = 1'b0;
    logic [NC*NB-1:0]   sig = '0;
    logic [NB-1:0]      sin_r = '0;
    logic [NB-1:0]      cos_r = '0;
    logic [NC*NB-1:0]   x_o, y_o;
    logic               done_o, busy_o, drop_o;
    logic [31:0]        count_o;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_base;

    localparam longint P_HALF = 4194304;
    localparam longint P_MAX  = 8388607;
    localparam longint N_FULL = -8388608;

    multichannel_lockin #(.NUM_CH(NC), .NUM_BITS(NB), .DECIM_LOG2(DL)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .tick_i  (tick),
        .sig_i   (sig),
        .sin_i   (sin_r),
        .cos_i   (cos_r),
        .x_o     (x_o),
        .y_o     (y_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .drop_o  (drop_o),
        .count_o (count_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_o) done_cnt++;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint xch(input int k);
        logic signed [NB-1:0] v;
        v = x_o[k*NB +: NB];
        return longint'(v);
    endfunction

    function automatic longint ych(input int k);
        logic signed [NB-1:0] v;
        v = y_o[k*NB +: NB];
        return longint'(v);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after an edge; the tick is sampled on the following edge.
    task automatic send(input longint c0, input longint c1, input longint s, input longint c);
        tick  = 1'b1;
        sig   = {NB'(c1), NB'(c0)};
        sin_r = NB'(s);
        cos_r = NB'(c);
        @(posedge clk);
        #1;
        tick  = 1'b0;
    endtask

    task automatic run_block(input longint c0, input longint c1, input longint s, input longint c);
        for (int i = 0; i < 4; i++) begin
            send(c0, c1, s, c);
            wait_cyc(7);
        end
    endtask

    initial begin
        wait_cyc(3);
        chk("rst_x", longint'(x_o), 0);
        chk("rst_y", longint'(y_o), 0);
        chk("rst_count", longint'(count_o), 0);
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_drop", longint'(drop_o), 0);
        chk("rst_done", longint'(done_o), 0);
        reset = 1'b0;
        wait_cyc(1);

        // 1: ch0 half scale against full-scale sin
        done_base = done_cnt;
        run_block(P_HALF, 0, P_MAX, 0);
        chk("t1_done", longint'(done_cnt - done_base), 1);
        chk("t1_x0", xch(0), 4194303);
        chk("t1_y0", ych(0), 0);
        chk("t1_x1", xch(1), 0);
        chk("t1_count", longint'(count_o), 1);
        chk("t1_busy", longint'(busy_o), 0);

        // 2: ch1 most-negative squared saturates positive
        run_block(0, N_FULL, N_FULL, N_FULL);
        chk("t2_x1", xch(1), P_MAX);
        chk("t2_y1", ych(1), P_MAX);
        chk("t2_x0", xch(0), 0);
        chk("t2_y0", ych(0), 0);
        chk("t2_count", longint'(count_o), 2);

        // 3: quadrature only, with latency check
        for (int i = 0; i < 3; i++) begin
            send(P_HALF, 0, 0, N_FULL);
            wait_cyc(7);
        end
        send(P_HALF, 0, 0, N_FULL);
        wait_cyc(5);
        chk("t3_done_early", longint'(done_o), 0);
        chk("t3_y0_hold", ych(0), 0);
        wait_cyc(1);
        chk("t3_done_edge", longint'(done_o), 1);
        chk("t3_y0", ych(0), -4194304);
        chk("t3_x0", xch(0), 0);
        chk("t3_count", longint'(count_o), 3);
        wait_cyc(1);
        chk("t3_done_pulse", longint'(done_o), 0);

        // 4: tick during MAC is dropped and must not disturb the sums
        send(P_HALF, 0, P_MAX, 0);
        wait_cyc(2);
        send(N_FULL, N_FULL, N_FULL, N_FULL);
        chk("t4_drop", longint'(drop_o), 1);
        wait_cyc(6);
        for (int i = 0; i < 3; i++) begin
            send(P_HALF, 0, P_MAX, 0);
            wait_cyc(7);
        end
        chk("t4_x0", xch(0), 4194303);
        chk("t4_y0", ych(0), 0);
        chk("t4_x1", xch(1), 0);
        chk("t4_drop_sticky", longint'(drop_o), 1);
        chk("t4_count", longint'(count_o), 4);

        // 5: reset mid-block discards partial sums
        for (int i = 0; i < 2; i++) begin
            send(N_FULL, N_FULL, N_FULL, N_FULL);
            wait_cyc(7);
        end
        send(N_FULL, N_FULL, N_FULL, N_FULL);
        wait_cyc(1);
        reset = 1'b1;
        wait_cyc(1);
        chk("t5_rst_x", longint'(x_o), 0);
        chk("t5_rst_y", longint'(y_o), 0);
        chk("t5_rst_count", longint'(count_o), 0);
        chk("t5_rst_busy", longint'(busy_o), 0);
        chk("t5_rst_drop", longint'(drop_o), 0);
        reset = 1'b0;
        wait_cyc(1);
        run_block(P_HALF, 0, P_MAX, 0);
        chk("t5_x0", xch(0), 4194303);
        chk("t5_y0", ych(0), 0);
        chk("t5_x1", xch(1), 0);
        chk("t5_y1", ych(1), 0);
        chk("t5_count", longint'(count_o), 1);

        // 6: back-to-back ticks at the minimum guaranteed spacing
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
        done_base = done_cnt;
        for (int i = 0; i < 16; i++) begin
            send(P_HALF, 0, P_MAX, 0);
            wait_cyc(5);
            if (i % 4 != 3)
                chk("t6_gap_busy", longint'(busy_o), 0);
        end
        wait_cyc(8);
        chk("t6_done", longint'(done_cnt - done_base), 4);
        chk("t6_count", longint'(count_o), 4);
        chk("t6_drop", longint'(drop_o), 0);
        chk("t6_x0", xch(0), 4194303);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
